// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order instruction FIFO between decode and ROB/RS/LSRS.
// Pops the head when ROB, target station and core are all available; outputs are registered.
module dispatch_queue #(
  parameter int              DEPTH   = 4,
  parameter int              NUM_CDB = 2,
  parameter int              ROB_AW  = 4,
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] NOP_OP  = OP_W'(0),
  parameter logic [OP_W-1:0] LS_LO   = OP_W'(11),
  parameter logic [OP_W-1:0] LS_HI   = OP_W'(18),
  parameter logic [OP_W-1:0] BR_LO   = OP_W'(1),
  parameter logic [OP_W-1:0] BR_HI   = OP_W'(10)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [OP_W-1:0]         in_op_i,
  input  logic [31:0]             in_pc_i,
  input  logic [31:0]             in_imm_i,
  input  logic [4:0]              in_rs1_i,
  input  logic [4:0]              in_rs2_i,
  input  logic [4:0]              in_rd_i,
  output logic [4:0]              r1_addr_o,
  output logic [4:0]              r2_addr_o,
  input  logic [ROB_AW-1:0]       r1_id_i,
  input  logic [ROB_AW-1:0]       r2_id_i,
  input  logic [31:0]             r1_data_i,
  input  logic [31:0]             r2_data_i,
  input  logic [ROB_AW-1:0]       rob_free_id_i,
  input  logic [NUM_CDB-1:0]      cdb_en_i,
  input  logic [NUM_CDB*ROB_AW-1:0] cdb_id_i,
  input  logic [NUM_CDB*32-1:0]   cdb_data_i,
  input  logic                    rs_full_i,
  input  logic                    lsrs_full_i,
  output logic                    rs_en_o,
  output logic                    lsrs_en_o,
  output logic [OP_W-1:0]         iss_op_o,
  output logic [31:0]             iss_pc_o,
  output logic [31:0]             iss_imm_o,
  output logic [31:0]             iss_v1_o,
  output logic [31:0]             iss_v2_o,
  output logic [ROB_AW-1:0]       iss_q1_o,
  output logic [ROB_AW-1:0]       iss_q2_o,
  output logic [ROB_AW-1:0]       iss_id_o,
  output logic                    rob_en_o,
  output logic [ROB_AW-1:0]       rob_id_o,
  output logic [4:0]              rob_rd_o,
  output logic [31:0]             rob_pc_o,
  output logic [1:0]              rob_br_o,
  output logic                    lock_en_o,
  output logic [ROB_AW-1:0]       lock_id_o,
  output logic [4:0]              lock_addr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     pc;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            head;
  logic              empty, push, pop, head_ls, head_br, target_full;
  logic [ROB_AW+31:0] opnd1, opnd2;

  assign empty       = (count_q == '0);
  assign head        = mem_q[rptr_q];
  assign head_ls     = (head.op >= LS_LO) && (head.op <= LS_HI);
  assign head_br     = (head.op >= BR_LO) && (head.op <= BR_HI);
  assign target_full = head_ls ? lsrs_full_i : rs_full_i;

  // Full blocks enqueue even when the head pops in the same cycle.
  assign in_ready_o = (count_q < CW'(DEPTH)) && rdy && !flush_i;
  assign push       = in_valid_i && in_ready_o && (in_op_i != NOP_OP);
  assign pop        = !empty && rdy && !flush_i && (rob_free_id_i != '0) && !target_full;

  assign r1_addr_o = empty ? 5'd0 : head.rs1;
  assign r2_addr_o = empty ? 5'd0 : head.rs2;

  // Lowest-numbered matching CDB channel wins, so scan from the top down.
  function automatic logic [ROB_AW+31:0] capture(input logic [ROB_AW-1:0] id,
                                                 input logic [31:0]       data);
    logic [ROB_AW+31:0] r;
    r = {id, data};
    if (id != '0)
      for (int k = NUM_CDB - 1; k >= 0; k--)
        if (cdb_en_i[k] && (cdb_id_i[k*ROB_AW +: ROB_AW] == id))
          r = {{ROB_AW{1'b0}}, cdb_data_i[k*32 +: 32]};
    return r;
  endfunction

  assign opnd1 = capture(r1_id_i, r1_data_i);
  assign opnd2 = capture(r2_id_i, r2_data_i);

  // NOTE: combinational next-state uses blocking assignments with a default
  // first, so every path assigns every signal and no latch is inferred.
  always_comb begin
    rptr_d  = rptr_q + AW'(pop);
    wptr_d  = wptr_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: the entry storage has no reset; count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{op: in_op_i, pc: in_pc_i, imm: in_imm_i,
                                 rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      rs_en_o     <= 1'b0;
      lsrs_en_o   <= 1'b0;
      rob_en_o    <= 1'b0;
      lock_en_o   <= 1'b0;
      iss_op_o    <= '0;
      iss_pc_o    <= '0;
      iss_imm_o   <= '0;
      iss_v1_o    <= '0;
      iss_v2_o    <= '0;
      iss_q1_o    <= '0;
      iss_q2_o    <= '0;
      iss_id_o    <= '0;
      rob_id_o    <= '0;
      rob_rd_o    <= '0;
      rob_pc_o    <= '0;
      rob_br_o    <= '0;
      lock_id_o   <= '0;
      lock_addr_o <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      rs_en_o   <= pop && !head_ls;
      lsrs_en_o <= pop && head_ls;
      rob_en_o  <= pop;
      lock_en_o <= pop && (head.rd != 5'd0);
      if (pop) begin
        iss_op_o    <= head.op;
        iss_pc_o    <= head.pc;
        iss_imm_o   <= head.imm;
        {iss_q1_o, iss_v1_o} <= opnd1;
        {iss_q2_o, iss_v2_o} <= opnd2;
        iss_id_o    <= rob_free_id_i;
        rob_id_o    <= rob_free_id_i;
        rob_rd_o    <= head.rd;
        rob_pc_o    <= head.pc;
        rob_br_o    <= head_br ? 2'd0 : 2'd2;
        lock_id_o   <= rob_free_id_i;
        lock_addr_o <= head.rd;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed plan steps plus random traffic checked against a
// queue-based reference model of the dispatch rules.
module tb_dispatch_queue;
  localparam int DEPTH = 4, NUM_CDB = 2, ROB_AW = 4, OP_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, flush_i, in_valid_i, in_ready_o;
  logic [OP_W-1:0] in_op_i;
  logic [31:0] in_pc_i, in_imm_i, r1_data_i, r2_data_i;
  logic [4:0] in_rs1_i, in_rs2_i, in_rd_i, r1_addr_o, r2_addr_o;
  logic [ROB_AW-1:0] r1_id_i, r2_id_i, rob_free_id_i;
  logic [NUM_CDB-1:0] cdb_en_i;
  logic [NUM_CDB*ROB_AW-1:0] cdb_id_i;
  logic [NUM_CDB*32-1:0] cdb_data_i;
  logic rs_full_i, lsrs_full_i, rs_en_o, lsrs_en_o, rob_en_o, lock_en_o;
  logic [OP_W-1:0] iss_op_o;
  logic [31:0] iss_pc_o, iss_imm_o, iss_v1_o, iss_v2_o, rob_pc_o;
  logic [ROB_AW-1:0] iss_q1_o, iss_q2_o, iss_id_o, rob_id_o, lock_id_o;
  logic [4:0] rob_rd_o, lock_addr_o;
  logic [1:0] rob_br_o;

  dispatch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_op_i(in_op_i), .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
    .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o),
    .r1_id_i(r1_id_i), .r2_id_i(r2_id_i), .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
    .rob_free_id_i(rob_free_id_i), .cdb_en_i(cdb_en_i), .cdb_id_i(cdb_id_i),
    .cdb_data_i(cdb_data_i), .rs_full_i(rs_full_i), .lsrs_full_i(lsrs_full_i),
    .rs_en_o(rs_en_o), .lsrs_en_o(lsrs_en_o), .iss_op_o(iss_op_o), .iss_pc_o(iss_pc_o),
    .iss_imm_o(iss_imm_o), .iss_v1_o(iss_v1_o), .iss_v2_o(iss_v2_o),
    .iss_q1_o(iss_q1_o), .iss_q2_o(iss_q2_o), .iss_id_o(iss_id_o),
    .rob_en_o(rob_en_o), .rob_id_o(rob_id_o), .rob_rd_o(rob_rd_o), .rob_pc_o(rob_pc_o),
    .rob_br_o(rob_br_o), .lock_en_o(lock_en_o), .lock_id_o(lock_id_o),
    .lock_addr_o(lock_addr_o)
  );

  typedef struct {
    logic [OP_W-1:0] op;
    logic [31:0] pc, imm;
    logic [4:0] rs1, rs2, rd;
  } ent_t;

  ent_t mq[$];
  logic e_rs_en, e_lsrs_en, e_rob_en, e_lock_en;
  logic [OP_W-1:0] e_op;
  logic [31:0] e_pc, e_imm, e_v1, e_v2;
  logic [ROB_AW-1:0] e_q1, e_q2, e_id;
  logic [4:0] e_rd;
  logic [1:0] e_br;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    {e_rs_en, e_lsrs_en, e_rob_en, e_lock_en} = '0;
    e_op = '0; e_pc = '0; e_imm = '0; e_v1 = '0; e_v2 = '0;
    e_q1 = '0; e_q2 = '0; e_id = '0; e_rd = '0; e_br = '0;
  endtask

  function automatic bit is_ls(input logic [OP_W-1:0] op);
    return (op >= 11) && (op <= 18);
  endfunction

  task automatic operand(input logic [ROB_AW-1:0] id, input logic [31:0] data,
                         output logic [ROB_AW-1:0] q, output logic [31:0] v);
    q = id; v = data;
    if (id == 0) begin q = 0; return; end
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_en_i[k] && cdb_id_i[k*ROB_AW +: ROB_AW] == id) begin
        q = 0; v = cdb_data_i[k*32 +: 32]; return;
      end
  endtask

  task automatic check_regs();
    chk("rs_en", rs_en_o, e_rs_en);
    chk("lsrs_en", lsrs_en_o, e_lsrs_en);
    chk("rob_en", rob_en_o, e_rob_en);
    chk("lock_en", lock_en_o, e_lock_en);
    chk("iss_op", iss_op_o, e_op);
    chk("iss_pc", iss_pc_o, e_pc);
    chk("rob_pc", rob_pc_o, e_pc);
    chk("iss_imm", iss_imm_o, e_imm);
    chk("iss_v1", iss_v1_o, e_v1);
    chk("iss_v2", iss_v2_o, e_v2);
    chk("iss_q1", iss_q1_o, e_q1);
    chk("iss_q2", iss_q2_o, e_q2);
    chk("iss_id", iss_id_o, e_id);
    chk("rob_id", rob_id_o, e_id);
    chk("lock_id", lock_id_o, e_id);
    chk("rob_rd", rob_rd_o, e_rd);
    chk("lock_addr", lock_addr_o, e_rd);
    chk("rob_br", rob_br_o, e_br);
  endtask

  // One clock: check comb outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit ready, d;
    ent_t h;
    logic [4:0] ea1, ea2;
    #1;
    ready = (mq.size() < DEPTH) && rdy && !flush_i;
    ea1 = 0; ea2 = 0;
    if (mq.size() > 0) begin ea1 = mq[0].rs1; ea2 = mq[0].rs2; end
    chk("in_ready", in_ready_o, ready);
    chk("r1_addr", r1_addr_o, ea1);
    chk("r2_addr", r2_addr_o, ea2);
    d = 0;
    if (mq.size() > 0)
      d = rdy && !flush_i && rob_free_id_i != 0 && !(is_ls(mq[0].op) ? lsrs_full_i : rs_full_i);
    {e_rs_en, e_lsrs_en, e_rob_en, e_lock_en} = '0;
    if (d) begin
      h = mq.pop_front();
      e_rs_en = !is_ls(h.op); e_lsrs_en = is_ls(h.op);
      e_rob_en = 1; e_lock_en = (h.rd != 0);
      e_op = h.op; e_pc = h.pc; e_imm = h.imm; e_rd = h.rd; e_id = rob_free_id_i;
      e_br = (h.op >= 1 && h.op <= 10) ? 2'd0 : 2'd2;
      operand(r1_id_i, r1_data_i, e_q1, e_v1);
      operand(r2_id_i, r2_data_i, e_q2, e_v2);
    end
    if (flush_i) mq.delete();
    if (ready && in_valid_i && in_op_i != 0)
      mq.push_back('{op: in_op_i, pc: in_pc_i, imm: in_imm_i,
                     rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i});
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic set_in(input logic v, input logic [OP_W-1:0] op, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] imm);
    in_valid_i = v; in_op_i = op; in_pc_i = pc; in_rs1_i = rs1; in_rs2_i = rs1 + 5'd1;
    in_rd_i = rd; in_imm_i = imm;
  endtask

  initial begin
    rst = 1; rdy = 1; flush_i = 0; set_in(0, 0, 0, 0, 0, 0);
    r1_id_i = 0; r2_id_i = 0; r1_data_i = 0; r2_data_i = 0; rob_free_id_i = 0;
    cdb_en_i = 0; cdb_id_i = 0; cdb_data_i = 0; rs_full_i = 0; lsrs_full_i = 0;
    model_reset();
    #12;
    check_regs();
    chk("reset_in_ready", in_ready_o, 1'b1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // ADDI dispatched the edge after enqueue
    set_in(1, 20, 32'h100, 1, 5, 7); r1_data_i = 3; r2_data_i = 9; rob_free_id_i = 4;
    cycle();
    chk("addi_not_yet", rs_en_o, 1'b0);
    in_valid_i = 0;
    cycle();
    chk("addi_rs_en", rs_en_o, 1'b1);
    chk("addi_v1", iss_v1_o, 32'd3);
    chk("addi_id", iss_id_o, 4'd4);
    chk("addi_lock_addr", lock_addr_o, 5'd5);
    chk("addi_br", rob_br_o, 2'd2);
    cycle();

    // LW held back by a full LSRS
    lsrs_full_i = 1; set_in(1, 13, 32'h104, 2, 6, 16);
    cycle();
    in_valid_i = 0;
    repeat (3) cycle();
    chk("lw_blocked", lsrs_en_o, 1'b0);
    lsrs_full_i = 0;
    cycle();
    chk("lw_lsrs_en", lsrs_en_o, 1'b1);
    chk("lw_rs_en", rs_en_o, 1'b0);
    cycle();
    chk("lw_single", lsrs_en_o, 1'b0);

    // CDB forwarding, lowest channel wins
    set_in(1, 20, 32'h108, 3, 7, 1); r1_id_i = 6;
    cdb_en_i = 2'b11; cdb_id_i = {4'd6, 4'd6}; cdb_data_i = {32'hBB, 32'hAA};
    cycle();
    in_valid_i = 0;
    cycle();
    chk("cdb_q1", iss_q1_o, 4'd0);
    chk("cdb_v1", iss_v1_o, 32'hAA);
    r1_id_i = 0; cdb_en_i = 0;

    // Fill while ROB is full, then drain across the wrap
    rob_free_id_i = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 6'(20 + i), 32'h200 + 32'(4 * i), 5'(i + 1), 5'(i + 8), 32'(i));
      if (i == 4) begin #1; chk("full_ready", in_ready_o, 1'b0); end
      cycle();
    end
    in_valid_i = 0;
    for (int i = 1; i <= 4; i++) begin
      rob_free_id_i = 4'(i);
      cycle();
      chk("drain_pc", iss_pc_o, 32'h200 + 32'(4 * (i - 1)));
    end
    cycle();

    // BEQ with rd=0
    set_in(1, 5, 32'h300, 4, 0, 8);
    cycle();
    in_valid_i = 0;
    cycle();
    chk("beq_br", rob_br_o, 2'd0);
    chk("beq_lock_en", lock_en_o, 1'b0);
    chk("beq_rs_en", rs_en_o, 1'b1);

    // Flush with a queue of 3 and a same-cycle push attempt
    rob_free_id_i = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 20, 32'h400 + 32'(4 * i), 1, 2, 0);
      cycle();
    end
    flush_i = 1; set_in(1, 21, 32'h500, 1, 2, 0);
    cycle();
    flush_i = 0; in_valid_i = 0; rob_free_id_i = 5;
    repeat (2) cycle();
    chk("flush_no_rob_en", rob_en_o, 1'b0);
    set_in(1, 22, 32'h600, 1, 3, 0);
    cycle();
    in_valid_i = 0;
    cycle();
    chk("post_flush_pc", iss_pc_o, 32'h600);

    // Random traffic with a mid-run asynchronous reset
    for (int n = 0; n < 400; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      set_in(1'($urandom_range(0, 3) != 0),
             sel == 0 ? 6'd0 : sel == 1 ? 6'd5 : sel == 2 ? 6'd13 : 6'($urandom),
             $urandom, 5'($urandom), 5'($urandom_range(0, 3)), $urandom);
      rdy = ($urandom_range(0, 7) != 0);
      flush_i = ($urandom_range(0, 29) == 0);
      rob_free_id_i = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      rs_full_i = ($urandom_range(0, 3) == 0);
      lsrs_full_i = ($urandom_range(0, 3) == 0);
      r1_id_i = 4'($urandom_range(0, 7)); r2_id_i = 4'($urandom_range(0, 7));
      r1_data_i = $urandom; r2_data_i = $urandom;
      cdb_en_i = 2'($urandom); cdb_id_i = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
      cdb_data_i = {$urandom, $urandom};
      cycle();
      if (n == 200) begin
        #2 rst = 1;
        #1 model_reset();
        check_regs();
        rst = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single-slot dispatch stage. Sits between ID and the ROB/RS/LSRS/regfile.
- Buffers up to DEPTH decoded instructions in an in-order FIFO and dispatches the head when all of these are available: a ROB slot, a target station slot and a non-paused core.
- Forwards from NUM_CDB broadcast buses in the capture cycle.
- All dispatch outputs are registered; flush support is included.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- NUM_CDB, 2, number of CDB channels snooped.
- ROB_AW, 4, ROB id width; id 0 reserved as "no tag / value ready".
- OP_W, 6, opcode width.
- NOP_OP, 0, opcode dropped at enqueue.
- LS_LO / LS_HI, 11 / 18, inclusive opcode range routed to LSRS.
- BR_LO / BR_HI, 1 / 10, inclusive opcode range tagged as branch/jump.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- rdy  in  1  core enable; low = pause
- flush_i  in  1  mispredict flush
- in_valid_i  in  1  ID offers an instruction
- in_ready_o  out  1  queue accepts; comb = (count<DEPTH)&&rdy&&!flush_i
- in_op_i / in_pc_i / in_imm_i  in  OP_W / 32 / 32  decoded fields
- in_rs1_i / in_rs2_i / in_rd_i  in  5 each  register addresses
- r1_addr_o / r2_addr_o  out  5  comb head rs1/rs2 to regfile (0 when empty)
- r1_id_i / r2_id_i  in  ROB_AW  regfile rename tag, 0 = ready
- r1_data_i / r2_data_i  in  32  regfile value
- rob_free_id_i  in  ROB_AW  next ROB id, 0 = ROB full
- cdb_en_i  in  NUM_CDB  per-channel valid
- cdb_id_i  in  NUM_CDB*ROB_AW  channel k at [k*ROB_AW +: ROB_AW]
- cdb_data_i  in  NUM_CDB*32  channel k at [k*32 +: 32]
- rs_full_i / lsrs_full_i  in  1  station full
- rs_en_o / lsrs_en_o  out  1  registered issue pulse
- iss_op_o, iss_pc_o, iss_imm_o  out  OP_W, 32, 32  issue payload
- iss_v1_o, iss_v2_o  out  32  operand values
- iss_q1_o, iss_q2_o  out  ROB_AW  operand tags
- iss_id_o  out  ROB_AW  assigned ROB id
- rob_en_o  out  1  ROB allocate pulse
- rob_id_o  out  ROB_AW  ROB id
- rob_rd_o  out  5  destination register
- rob_pc_o  out  32  instruction PC
- rob_br_o  out  2  0 = branch/jump, 2 = other
- lock_en_o  out  1  regfile rename pulse
- lock_id_o  out  ROB_AW  rename tag
- lock_addr_o  out  5  renamed register

Behaviour:
- Reset: count, read pointer and write pointer = 0. Every registered output = 0.
- Enqueue: on in_valid_i && in_ready_o at a rising edge, write the entry at wptr and advance wptr mod DEPTH.
  - An opcode equal to NOP_OP is accepted but not stored.
- Dispatch condition D (comb): count>0 && rdy && !flush_i && rob_free_id_i!=0 && !(target station full).
  - Target station = LSRS if LS_LO≤op≤LS_HI, else RS.
- When D holds at an edge:
  - Pop the head.
  - Register rob_en_o=1, lock_en_o=(rd!=0), and exactly one of rs_en_o/lsrs_en_o.
  - rob_id_o = iss_id_o = lock_id_o = rob_free_id_i; payload taken from the head.
- When D does not hold: all *_en_o = 0 next cycle; payload registers hold their last value.
- Operand capture, per operand n, when D holds:
  - If rn_id_i==0: qn=0, vn=rn_data_i.
  - Else if some k has cdb_en_i[k] && cdb_id_i[k]==rn_id_i: qn=0, vn=data of the lowest such k.
  - Else: qn=rn_id_i, vn=rn_data_i.
- Latency: an instruction enqueued at edge N dispatches at edge N+1 at the earliest, with its enables visible in cycle N+1. No same-edge bypass.
- Throughput: 1 enqueue and 1 dispatch per cycle. A simultaneous push and pop leaves count unchanged.
- Full: count==DEPTH makes in_ready_o=0, even if a pop occurs in the same cycle.
- Empty: no dispatch; r1/r2 addresses drive 0.
- Wrap-around: both pointers wrap mod DEPTH; order is preserved across the wrap.
- Flush: at that edge, count=0, rptr=wptr=0, all *_en_o=0. Same-cycle enqueue is blocked because in_ready_o is 0.
- rdy low: no state change; enables deassert next edge.
- rst asserted mid-operation clears everything immediately (asynchronous).

Test Plan:
- Reset, then enqueue ADDI (op 20, rs1=1, rd=5, imm=7) with r1_id=0, r1_data=3, rob_free_id=4 → the edge after enqueue gives rs_en=1, iss_v1=3, iss_q1=0, iss_id=4, lock_en=1, lock_addr=5, rob_br=2.
- LW (op 13) with lsrs_full_i=1 for 3 cycles, then 0 → no enables while full; then lsrs_en=1 on exactly one cycle; rs_en stays 0.
- Operand tag r1_id=6, with cdb_en=2'b11 and both channels carrying id 6 (data 0xAA on ch0, 0xBB on ch1) in the capture cycle → iss_q1=0, iss_v1=0xAA.
- Fill with 5 pushes while rob_free_id=0 → 4 accepted, in_ready=0 on the 5th. Then set rob_free_id=1..4 → 4 dispatches in FIFO order across the pointer wrap.
- BEQ with rd=0 → rob_br=0, lock_en=0, rs_en=1.
- Queue holding 3 entries, flush_i pulsed with in_valid_i=1 → no enables afterwards, count 0, that instruction not accepted. Next push dispatches normally.
